// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with an optional direct-mapped BTB.
//
// Holds the program counter, presents it to a combinational-read instruction
// memory, and forwards the returned word together with its PC and a
// branch-taken prediction to the IF/ID register.
//
// Configuration macro: IF_STAGE_BTB_EN
//   defined   -> BTB with 2-bit saturating counters predicts taken branches
//   undefined -> no BTB; predicted_taken is constant 0, upd_* are ignored
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   en                1 = advance PC, 0 = hold PC
//   redirect          control-flow correction from EX, wins over en
//   redirect_pc       corrected fetch address
//   upd_valid         resolved-branch update strobe from EX
//   upd_pc            PC of the resolved branch
//   upd_taken         resolved direction
//   upd_target        resolved target
//   imem_addr         instruction memory address (the PC register)
//   imem_rdata        instruction word at imem_addr, same cycle
//   pc_out            PC of the fetched instruction
//   instr_out         fetched instruction (imem_rdata)
//   predicted_taken   BTB prediction for pc_out
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        predicted_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic        predicted_taken_s;
  logic [31:0] pred_target_s;

`ifdef IF_STAGE_BTB_EN
  // Valid bits and counters are reset; tags and targets are not, since an
  // entry is only trusted once its valid bit is set again.
  logic [BTB_ENTRIES-1:0] valid_r;
  logic [1:0]             ctr_r [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_r [BTB_ENTRIES];
  logic [29:0]            tgt_r [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic             rd_hit_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic [1:0]       up_ctr_s;
  logic [1:0]       up_ctr_next_s;
  logic             unused_s;

  assign rd_idx_s = pc_r[IDX_W+1:2];
  assign rd_tag_s = pc_r[31:IDX_W+2];
  assign up_idx_s = upd_pc[IDX_W+1:2];
  assign up_tag_s = upd_pc[31:IDX_W+2];
  // Targets are stored word-aligned, so the low bits never matter.
  assign unused_s = ^{upd_pc[1:0], upd_target[1:0], redirect_pc[1:0]};

  // Lookup on the current PC; sees pre-update contents of a same-cycle write.
  always_comb begin
    rd_hit_s          = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
    predicted_taken_s = rd_hit_s && ctr_r[rd_idx_s][1];
    pred_target_s     = {tgt_r[rd_idx_s], 2'b00};
  end

  // Update-side hit detection and saturating counter arithmetic.
  always_comb begin
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    up_ctr_s = ctr_r[up_idx_s];
    if (upd_taken) begin
      up_ctr_next_s = (up_ctr_s == 2'b11) ? 2'b11 : up_ctr_s + 2'b01;
    end else begin
      up_ctr_next_s = (up_ctr_s == 2'b00) ? 2'b00 : up_ctr_s - 2'b01;
    end
  end

  // Valid bits and counters: cleared on reset, trained by resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_r[i] <= 2'b00;
      end
    end else if (upd_valid) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= up_ctr_next_s;
      end else if (upd_taken) begin
        valid_r[up_idx_s] <= 1'b1;
        ctr_r[up_idx_s]   <= 2'b10;
      end else begin
        valid_r <= valid_r;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and target: written on any taken update (allocate or hit refresh).
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_r[up_idx_s] <= up_tag_s;
      tgt_r[up_idx_s] <= upd_target[31:2];
    end
  end
`else
  logic unused_s;

  assign unused_s = ^{upd_valid, upd_pc, upd_taken, upd_target, redirect_pc[1:0]};

  // Without a BTB every fetch is predicted not-taken.
  always_comb begin
    predicted_taken_s = 1'b0;
    pred_target_s     = 32'h0000_0000;
  end
`endif

  // Next-PC selection: redirect beats en; a stall holds the PC.
  always_comb begin
    if (redirect) begin
      next_pc_s = {redirect_pc[31:2], 2'b00};
    end else if (en) begin
      if (predicted_taken_s) begin
        next_pc_s = pred_target_s;
      end else begin
        next_pc_s = pc_r + 32'd4;
      end
    end else begin
      next_pc_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign imem_addr       = pc_r;
  assign pc_out          = pc_r;
  assign instr_out       = imem_rdata;
  assign predicted_taken = predicted_taken_s;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A behavioural model (PC value plus a direct-mapped table of
// valid/tag/target/counter) tracks the expected state; every cycle the DUT
// outputs are compared against it. Directed sequences with literal
// expectations come first, then randomized traffic including mid-run resets.
// Works for builds with and without IF_STAGE_BTB_EN.
// -----------------------------------------------------------------------------
module tb_if_stage;

`ifdef IF_STAGE_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif
  localparam int N  = 16;
  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        predicted_taken;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Model state.
  logic [31:0] m_pc = 32'h0;
  bit          m_valid [N];
  logic [31:0] m_tagv  [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .predicted_taken(predicted_taken)
  );

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> (2 + IW);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return BTB_ON && m_valid[midx(pc)] && (m_tagv[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cyc(input bit r, input bit red, input logic [31:0] rpc, input bit e,
                     input bit uv, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utgt);
    logic [31:0] nxt;
    int i;
    rst = r; redirect = red; redirect_pc = rpc; en = e;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    if (r)        nxt = 32'h0000_0000;
    else if (red) nxt = rpc & ~32'h3;
    else if (e)   nxt = m_pred(m_pc) ? m_tgt[midx(m_pc)] : m_pc + 32'd4;
    else          nxt = m_pc;
    i = midx(upc);
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 0;
      end
    end else if (uv && BTB_ON) begin
      if (m_hit(upc)) begin
        m_ctr[i] = ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                      : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (ut) m_tgt[i] = utgt & ~32'h3;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tagv[i]  = mtag(upc);
        m_tgt[i]   = utgt & ~32'h3;
        m_ctr[i]   = 2;
      end
    end
    @(posedge clk);
    #1;
    m_pc = nxt;
    n_vec++;
    check("pc_out", pc_out, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("instr_out", instr_out, mem_word(m_pc));
    check("predicted_taken", {31'h0, predicted_taken}, {31'h0, m_pred(m_pc)});
  endtask

  initial begin
    // Reset, then four fetches: 0, 4, 8, 12, never predicted taken.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("reset_pc", pc_out, 32'h0000_0000);
    check("reset_pred", {31'h0, predicted_taken}, 32'h0);
    for (int k = 1; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("seq_pc", pc_out, 32'(4 * k));
      check("seq_pred", {31'h0, predicted_taken}, 32'h0);
    end

    // Redirect while stalled; low bits of redirect_pc dropped.
    cyc(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("redir_a", pc_out, 32'h0000_0010);
    cyc(1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("redir_stall", pc_out, 32'h0000_0200);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_hold", pc_out, 32'h0000_0200);

    // Allocate 0x40 -> 0x100 and fetch it.
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100);
    check("alloc_pred", {31'h0, predicted_taken}, {31'h0, BTB_ON});
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("alloc_next", pc_out, BTB_ON ? 32'h0000_0100 : 32'h0000_0044);

    // Two not-taken updates: counter 10 -> 00, fetch falls through.
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    check("nt_pred", {31'h0, predicted_taken}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("nt_next", pc_out, 32'h0000_0044);
    // Third not-taken saturates at 00: one taken step only reaches 01.
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100);
    check("sat_low_pred", {31'h0, predicted_taken}, 32'h0);

    // Wraparound of PC+4.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap", pc_out, 32'h0000_0000);

    // Reset overrides redirect, en and update in the same cycle.
    cyc(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0500);
    check("rst_override_pc", pc_out, 32'h0000_0000);
    check("rst_override_pred", {31'h0, predicted_taken}, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] rpc;
      logic [31:0] upc;
      rpc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 1023));
      upc = 32'($urandom_range(0, 1023));
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, rpc,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0, upc,
          $urandom_range(0, 2) != 0, 32'($urandom_range(0, 1023)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
